imem_loader: RTL and testbench

//   Writer side of instruction_memory: receives a framed byte stream from a host

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host-link byte stream and instruction-memory write port of the program loader.
// The master side is the host/bench; the loader itself uses the slave modport.
interface imem_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic [15:0] words_loaded;
    logic        done;
    logic        error;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, words_loaded, done, error
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, words_loaded, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (count, big-endian words,
// XOR checksum), writes words into instruction memory and holds the CPU meanwhile.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR
    } state_t;

    state_t           state, state_next;
    logic [7:0]       cnt_hi_q;
    logic [15:0]      word_count;
    logic [15:0]      words_q;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift_q;
    logic [IDX_W-1:0] idx;
    logic [7:0]       xor_q;
    logic             wr_en_q;
    logic [31:0]      wr_addr_q;
    logic [31:0]      wr_data_q;

    logic        busy;
    logic        accept;
    logic        idle_like;
    logic [15:0] count_in;
    logic        word_complete;
    logic        last_word;

    assign busy          = (state == CNT_HI) || (state == CNT_LO) ||
                           (state == DATA)   || (state == CHECK);
    assign idle_like     = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign accept        = bus.byte_valid && busy;
    assign count_in      = {cnt_hi_q, bus.byte_data};
    assign word_complete = (state == DATA) && accept && (byte_cnt == 2'd3);
    // words_q still holds the index of the word being completed here.
    assign last_word     = (words_q == word_count - 16'd1);

    assign bus.byte_ready   = busy;
    assign bus.cpu_hold     = busy;
    assign bus.done         = (state == DONE);
    assign bus.error        = (state == ERROR);
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.words_loaded = words_q;

    // NOTE: asynchronous reset lives in the sensitivity list; all state uses <=.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: if (bus.start) state_next = CNT_HI;
            CNT_HI:            if (accept) state_next = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (count_in == 16'd0)        state_next = CHECK;
                    else if (count_in > DEPTH_W)  state_next = ERROR;
                    else                          state_next = DATA;
                end
            end
            // Leaving DATA on the final byte lets a checksum byte arriving in the
            // write-strobe cycle be consumed as the checksum.
            DATA:  if (word_complete && last_word) state_next = CHECK;
            CHECK: if (accept) state_next = (bus.byte_data == xor_q) ? DONE : ERROR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_hi_q   <= '0;
            word_count <= '0;
            words_q    <= '0;
            byte_cnt   <= '0;
            shift_q    <= '0;
            idx        <= '0;
            xor_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (idle_like && bus.start) begin
                word_count <= '0;
                words_q    <= '0;
                byte_cnt   <= '0;
                shift_q    <= '0;
                idx        <= '0;
                xor_q      <= '0;
            end
            if (accept) begin
                xor_q <= xor_q ^ bus.byte_data;
                case (state)
                    CNT_HI: cnt_hi_q   <= bus.byte_data;
                    CNT_LO: word_count <= count_in;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift_q  <= {shift_q[15:0], bus.byte_data};
                        if (byte_cnt == 2'd3) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {shift_q, bus.byte_data};
                            wr_addr_q <= 32'(idx) << 2;
                            idx       <= idx + 1'b1;
                            words_q   <= words_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as frames are driven
// and compared by a monitor whenever the loader strobes wr_en.
module tb_imem_loader;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   wr_count = 0;
    logic [31:0] last_addr = '0;

    logic [63:0] exp_q[$];
    logic [31:0] frame_words[$];

    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            logic [63:0] e;
            wr_count++;
            last_addr = bus.wr_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, e[63:32]);
                check("wr_data", bus.wr_data, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        forever begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) begin
                step();
                break;
            end
            n++;
            if (n > 200) begin
                check("byte_accept_timeout", 32'd0, 32'd1);
                step();
                break;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    // Sends a complete frame built from frame_words; ck_flip corrupts the checksum.
    task automatic send_frame(input int n, input logic [7:0] ck_flip, input bit gaps,
                              input bit mid_start);
        logic [7:0]  ck = 8'h00;
        logic [15:0] nn = 16'(n);
        logic [7:0]  b;
        int          sent = 0;
        pulse_start();
        send_byte(nn[15:8], gaps); ck ^= nn[15:8];
        send_byte(nn[7:0],  gaps); ck ^= nn[7:0];
        for (int w = 0; w < n; w++) begin
            for (int k = 3; k >= 0; k--) begin
                b = frame_words[w][8*k +: 8];
                if (k == 0) exp_q.push_back({32'(w) << 2, frame_words[w]});
                if (mid_start && sent == 3) pulse_start();
                send_byte(b, gaps);
                ck ^= b;
                sent++;
            end
        end
        if (mid_start) pulse_start();
        send_byte(ck ^ ck_flip, gaps);
        repeat (2) step();
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic [15:0] wl);
        check({tag, "_done"},     32'(bus.done),         32'(d));
        check({tag, "_error"},    32'(bus.error),        32'(e));
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold),     32'd0);
        check({tag, "_words"},    32'(bus.words_loaded), 32'(wl));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},    32'(bus.byte_ready),   32'd0);
        check({tag, "_wr_en"},    32'(bus.wr_en),        32'd0);
        check({tag, "_wr_addr"},  bus.wr_addr,           32'd0);
        check({tag, "_wr_data"},  bus.wr_data,           32'd0);
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold),     32'd0);
        check({tag, "_words"},    32'(bus.words_loaded), 32'd0);
        check({tag, "_done"},     32'(bus.done),         32'd0);
        check({tag, "_error"},    32'(bus.error),        32'd0);
    endtask

    initial begin
        int wr_before;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // 1: two-word frame with good checksum
        frame_words = '{32'h2008_0005, 32'h2009_0003};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("hold_in_frame",  32'(bus.cpu_hold),   32'd1);
        check("ready_in_frame", 32'(bus.byte_ready), 32'd1);
        reset = 1'b1; #1; reset = 1'b0; step();
        send_frame(2, 8'h00, 1'b0, 1'b0);
        check_status("s1", 1'b1, 1'b0, 16'd2);

        // 2: same frame, checksum 0x06 instead of 0x05
        send_frame(2, 8'h03, 1'b0, 1'b0);
        check_status("s2", 1'b0, 1'b1, 16'd2);

        // 3: empty frame, good then bad checksum
        wr_before = wr_count;
        send_frame(0, 8'h00, 1'b0, 1'b0);
        check_status("s3_good", 1'b1, 1'b0, 16'd0);
        send_frame(0, 8'h01, 1'b0, 1'b0);
        check_status("s3_bad", 1'b0, 1'b1, 16'd0);
        check("s3_no_writes", 32'(wr_count - wr_before), 32'd0);

        // 4: count exceeds DEPTH; rejected right after the count bytes
        wr_before = wr_count;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b0);
        check("s4_error", 32'(bus.error),      32'd1);
        check("s4_ready", 32'(bus.byte_ready), 32'd0);
        check("s4_hold",  32'(bus.cpu_hold),   32'd0);
        repeat (3) step();
        check("s4_no_writes", 32'(wr_count - wr_before), 32'd0);

        // 5: reset mid-word, then a fresh frame
        wr_before = wr_count;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("s5_reset");
        step();
        reset = 1'b0;
        step();
        check("s5_no_writes", 32'(wr_count - wr_before), 32'd0);
        send_frame(2, 8'h00, 1'b0, 1'b0);
        check_status("s5_fresh", 1'b1, 1'b0, 16'd2);

        // 6: gaps and stray start pulses mid-frame, then a full-depth frame
        send_frame(2, 8'h00, 1'b1, 1'b1);
        check_status("s6_gaps", 1'b1, 1'b0, 16'd2);
        frame_words.delete();
        for (int i = 0; i < DEPTH; i++) frame_words.push_back($urandom());
        send_frame(DEPTH, 8'h00, 1'b0, 1'b0);
        check_status("s6_full", 1'b1, 1'b0, 16'(DEPTH));
        check("s6_last_addr", last_addr, 32'h0000_00FC);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
